// File: rtl/rv_iommu_ls_arbiter.sv
// rv_iommu_ls_arbiter
//   Shares the single IOMMU memory load/store port among NREQ internal
//   requesters (DDT/PDT walker, command-queue fetch, fault/page-request queue
//   writer). A round-robin arbiter registers at most one request per cycle
//   into the downstream port. Load/AMO responses come back tagged with the
//   granted requester index and are steered into a one-entry response
//   register per requester. Each requester has at most one response-bearing
//   request in flight; it is ineligible while that request is outstanding.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_*_i / req_trdy_o  per-requester request channels (packed by index)
//   rsp_*_o / rsp_trdy_i  per-requester response channels (packed by index)
//   m_req_*               downstream request channel (tag = requester index)
//   m_rsp_*               downstream response channel
//   err_o                 sticky protocol error (unexpected response tag)
module rv_iommu_ls_arbiter #(
  parameter int NREQ = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ*46-1:0]    req_addr_i,
  input  logic [NREQ*2-1:0]     req_op_i,
  input  logic [NREQ*2-1:0]     req_tag_i,
  input  logic [NREQ*7-1:0]     req_size_i,
  input  logic [NREQ-1:0]       req_irdy_i,
  output logic [NREQ-1:0]       req_trdy_o,
  output logic [NREQ*512-1:0]   rsp_data_o,
  output logic [NREQ-1:0]       rsp_acc_fault_o,
  output logic [NREQ-1:0]       rsp_poison_o,
  output logic [NREQ*2-1:0]     rsp_tag_o,
  output logic [NREQ-1:0]       rsp_irdy_o,
  input  logic [NREQ-1:0]       rsp_trdy_i,
  output logic [45:0]           m_req_addr_o,
  output logic [1:0]            m_req_op_o,
  output logic [6:0]            m_req_size_o,
  output logic [1:0]            m_req_tag_o,
  output logic                  m_req_irdy_o,
  input  logic                  m_req_trdy_i,
  input  logic [511:0]          m_rsp_data_i,
  input  logic                  m_rsp_acc_fault_i,
  input  logic                  m_rsp_poison_i,
  input  logic [1:0]            m_rsp_tag_i,
  input  logic                  m_rsp_irdy_i,
  output logic                  m_rsp_trdy_o,
  output logic                  err_o
);

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_AMO  = 2'd2;

  // Requester index reached by stepping 'step' positions past 'ptr'.
  function automatic logic [1:0] rr_next(input logic [1:0] ptr, input int step);
    int v;
    v = (int'(ptr) + step) % NREQ;
    return v[1:0];
  endfunction

  logic [NREQ-1:0]       busy_q, busy_d;
  logic [NREQ*2-1:0]     saved_tag_q, saved_tag_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic                  m_req_irdy_q, m_req_irdy_d;
  logic [45:0]           m_req_addr_q, m_req_addr_d;
  logic [1:0]            m_req_op_q, m_req_op_d;
  logic [6:0]            m_req_size_q, m_req_size_d;
  logic [1:0]            m_req_tag_q, m_req_tag_d;
  logic [NREQ-1:0]       rsp_irdy_q, rsp_irdy_d;
  logic [NREQ*512-1:0]   rsp_data_q, rsp_data_d;
  logic [NREQ-1:0]       rsp_fault_q, rsp_fault_d;
  logic [NREQ-1:0]       rsp_poison_q, rsp_poison_d;
  logic [NREQ*2-1:0]     rsp_tag_q, rsp_tag_d;
  logic                  err_q, err_d;

  logic [NREQ-1:0]       elig_s;
  logic                  free_s;
  logic                  grant_s;
  logic [1:0]            win_s;
  logic [NREQ-1:0]       grant_vec_s;
  logic [1:0]            win_op_s;
  logic                  win_is_rsp_s;
  logic [NREQ-1:0]       tag_hit_s;
  logic                  tgt_busy_s;
  logic                  tgt_free_s;
  logic                  m_rsp_trdy_s;
  logic                  rsp_xfer_s;
  logic                  rsp_bad_s;

  // Round-robin winner selection starting one past the last winner.
  always_comb begin
    elig_s  = req_irdy_i & ~busy_q;
    free_s  = !m_req_irdy_q || m_req_trdy_i;
    grant_s = 1'b0;
    win_s   = 2'd0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!rst && free_s && !grant_s && elig_s[rr_next(rr_ptr_q, i)]) begin
        grant_s = 1'b1;
        win_s   = rr_next(rr_ptr_q, i);
      end else begin
        grant_s = grant_s;
      end
    end
    for (int r = 0; r < NREQ; r++) begin
      grant_vec_s[r] = grant_s && (win_s == r[1:0]);
    end
    win_op_s     = req_op_i[int'(win_s)*2 +: 2];
    // Only LOAD and AMO return data; every other code behaves as a STORE.
    win_is_rsp_s = (win_op_s == OP_LOAD) || (win_op_s == OP_AMO);
  end

  // Downstream response decode: a tag naming a busy requester waits for its
  // response slot; any other tag is swallowed and reported as an error.
  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      tag_hit_s[r] = (m_rsp_tag_i == r[1:0]);
    end
    tgt_busy_s = |(tag_hit_s & busy_q);
    tgt_free_s = |(tag_hit_s & (~rsp_irdy_q | rsp_trdy_i));
    if (rst) begin
      m_rsp_trdy_s = 1'b0;
    end else if (tgt_busy_s) begin
      m_rsp_trdy_s = tgt_free_s;
    end else begin
      m_rsp_trdy_s = 1'b1;
    end
    rsp_xfer_s = m_rsp_irdy_i && m_rsp_trdy_s && tgt_busy_s;
    rsp_bad_s  = m_rsp_irdy_i && m_rsp_trdy_s && !tgt_busy_s;
  end

  // Next-state for the request register, busy tracking and response slots.
  always_comb begin
    busy_d       = busy_q;
    saved_tag_d  = saved_tag_q;
    rr_ptr_d     = rr_ptr_q;
    m_req_irdy_d = m_req_irdy_q;
    m_req_addr_d = m_req_addr_q;
    m_req_op_d   = m_req_op_q;
    m_req_size_d = m_req_size_q;
    m_req_tag_d  = m_req_tag_q;
    rsp_irdy_d   = rsp_irdy_q;
    rsp_data_d   = rsp_data_q;
    rsp_fault_d  = rsp_fault_q;
    rsp_poison_d = rsp_poison_q;
    rsp_tag_d    = rsp_tag_q;
    err_d        = err_q | rsp_bad_s;

    if (grant_s) begin
      m_req_irdy_d = 1'b1;
      m_req_addr_d = req_addr_i[int'(win_s)*46 +: 46];
      m_req_op_d   = win_op_s;
      m_req_size_d = req_size_i[int'(win_s)*7 +: 7];
      m_req_tag_d  = win_s;
      rr_ptr_d     = win_s;
    end else if (m_req_trdy_i) begin
      m_req_irdy_d = 1'b0;
    end else begin
      m_req_irdy_d = m_req_irdy_q;
    end

    for (int r = 0; r < NREQ; r++) begin
      // A grant only goes to an idle requester, so it never collides with
      // the busy clear below.
      if (grant_vec_s[r] && win_is_rsp_s) begin
        busy_d[r]            = 1'b1;
        saved_tag_d[r*2 +: 2] = req_tag_i[r*2 +: 2];
      end else begin
        saved_tag_d[r*2 +: 2] = saved_tag_q[r*2 +: 2];
      end

      // A response landing in the same cycle the old one is taken keeps the
      // slot full and the requester busy.
      if (rsp_xfer_s && tag_hit_s[r]) begin
        rsp_irdy_d[r]           = 1'b1;
        rsp_data_d[r*512 +: 512] = m_rsp_data_i;
        rsp_fault_d[r]          = m_rsp_acc_fault_i;
        rsp_poison_d[r]         = m_rsp_poison_i;
        rsp_tag_d[r*2 +: 2]     = saved_tag_q[r*2 +: 2];
      end else if (rsp_irdy_q[r] && rsp_trdy_i[r]) begin
        rsp_irdy_d[r] = 1'b0;
        busy_d[r]     = 1'b0;
      end else begin
        rsp_irdy_d[r] = rsp_irdy_q[r];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      saved_tag_q  <= '0;
      rr_ptr_q     <= 2'(NREQ - 1);
      m_req_irdy_q <= 1'b0;
      m_req_addr_q <= 46'd0;
      m_req_op_q   <= 2'd0;
      m_req_size_q <= 7'd0;
      m_req_tag_q  <= 2'd0;
      rsp_irdy_q   <= '0;
      rsp_data_q   <= '0;
      rsp_fault_q  <= '0;
      rsp_poison_q <= '0;
      rsp_tag_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      saved_tag_q  <= saved_tag_d;
      rr_ptr_q     <= rr_ptr_d;
      m_req_irdy_q <= m_req_irdy_d;
      m_req_addr_q <= m_req_addr_d;
      m_req_op_q   <= m_req_op_d;
      m_req_size_q <= m_req_size_d;
      m_req_tag_q  <= m_req_tag_d;
      rsp_irdy_q   <= rsp_irdy_d;
      rsp_data_q   <= rsp_data_d;
      rsp_fault_q  <= rsp_fault_d;
      rsp_poison_q <= rsp_poison_d;
      rsp_tag_q    <= rsp_tag_d;
      err_q        <= err_d;
    end
  end

  assign req_trdy_o      = grant_vec_s;
  assign m_rsp_trdy_o    = m_rsp_trdy_s;
  assign m_req_irdy_o    = m_req_irdy_q;
  assign m_req_addr_o    = m_req_addr_q;
  assign m_req_op_o      = m_req_op_q;
  assign m_req_size_o    = m_req_size_q;
  assign m_req_tag_o     = m_req_tag_q;
  assign rsp_irdy_o      = rsp_irdy_q;
  assign rsp_data_o      = rsp_data_q;
  assign rsp_acc_fault_o = rsp_fault_q;
  assign rsp_poison_o    = rsp_poison_q;
  assign rsp_tag_o       = rsp_tag_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_rv_iommu_ls_arbiter.sv
module tb_rv_iommu_ls_arbiter;

  localparam int NREQ = 3;
  localparam logic [1:0] LD  = 2'd0;
  localparam logic [1:0] ST  = 2'd1;
  localparam logic [1:0] AMO = 2'd2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ*46-1:0]   req_addr_i;
  logic [NREQ*2-1:0]    req_op_i;
  logic [NREQ*2-1:0]    req_tag_i;
  logic [NREQ*7-1:0]    req_size_i;
  logic [NREQ-1:0]      req_irdy_i;
  logic [NREQ-1:0]      req_trdy_o;
  logic [NREQ*512-1:0]  rsp_data_o;
  logic [NREQ-1:0]      rsp_acc_fault_o;
  logic [NREQ-1:0]      rsp_poison_o;
  logic [NREQ*2-1:0]    rsp_tag_o;
  logic [NREQ-1:0]      rsp_irdy_o;
  logic [NREQ-1:0]      rsp_trdy_i;
  logic [45:0]          m_req_addr_o;
  logic [1:0]           m_req_op_o;
  logic [6:0]           m_req_size_o;
  logic [1:0]           m_req_tag_o;
  logic                 m_req_irdy_o;
  logic                 m_req_trdy_i;
  logic [511:0]         m_rsp_data_i;
  logic                 m_rsp_acc_fault_i;
  logic                 m_rsp_poison_i;
  logic [1:0]           m_rsp_tag_i;
  logic                 m_rsp_irdy_i;
  logic                 m_rsp_trdy_o;
  logic                 err_o;

  rv_iommu_ls_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_addr_i(req_addr_i), .req_op_i(req_op_i), .req_tag_i(req_tag_i),
    .req_size_i(req_size_i), .req_irdy_i(req_irdy_i), .req_trdy_o(req_trdy_o),
    .rsp_data_o(rsp_data_o), .rsp_acc_fault_o(rsp_acc_fault_o),
    .rsp_poison_o(rsp_poison_o), .rsp_tag_o(rsp_tag_o),
    .rsp_irdy_o(rsp_irdy_o), .rsp_trdy_i(rsp_trdy_i),
    .m_req_addr_o(m_req_addr_o), .m_req_op_o(m_req_op_o),
    .m_req_size_o(m_req_size_o), .m_req_tag_o(m_req_tag_o),
    .m_req_irdy_o(m_req_irdy_o), .m_req_trdy_i(m_req_trdy_i),
    .m_rsp_data_i(m_rsp_data_i), .m_rsp_acc_fault_i(m_rsp_acc_fault_i),
    .m_rsp_poison_i(m_rsp_poison_i), .m_rsp_tag_i(m_rsp_tag_i),
    .m_rsp_irdy_i(m_rsp_irdy_i), .m_rsp_trdy_o(m_rsp_trdy_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract state: who is waiting for data, what each response slot holds,
  // what sits in the downstream request register, who won last, sticky error.
  bit           mb_busy [NREQ] = '{default: 1'b0};
  logic [1:0]   m_saved [NREQ] = '{default: 2'd0};
  bit           mr_v    [NREQ] = '{default: 1'b0};
  logic [511:0] mr_data [NREQ];
  logic         mr_f    [NREQ];
  logic         mr_p    [NREQ];
  logic [1:0]   mr_tag  [NREQ];
  bit           mo_v = 1'b0;
  logic [45:0]  mo_addr;
  logic [1:0]   mo_op;
  logic [6:0]   mo_size;
  logic [1:0]   mo_tag;
  int           m_last = NREQ - 1;
  bit           m_err = 1'b0;
  int           e_win, mc, mt, load_idx;
  bit           e_mrsp, e_tbusy;

  always begin
    @(negedge clk);
    e_win   = -1;
    e_mrsp  = 1'b0;
    e_tbusy = 1'b0;
    mt      = int'(m_rsp_tag_i);
    if (!rst) begin
      if (!mo_v || m_req_trdy_i) begin
        for (int k = 1; k <= NREQ; k++) begin
          mc = (m_last + k) % NREQ;
          if (e_win < 0 && req_irdy_i[mc] && !mb_busy[mc]) e_win = mc;
        end
      end
      e_tbusy = (mt < NREQ) && mb_busy[mt];
      e_mrsp  = e_tbusy ? (!mr_v[mt] || rsp_trdy_i[mt]) : 1'b1;
    end
    chk("req_trdy", req_trdy_o, (e_win >= 0) ? (3'b001 << e_win) : 3'b000);
    chk("m_rsp_trdy", m_rsp_trdy_o, e_mrsp);
    chk("m_req_irdy", m_req_irdy_o, mo_v);
    if (mo_v)
      chk("m_req_payload", {m_req_addr_o, m_req_op_o, m_req_size_o, m_req_tag_o},
          {mo_addr, mo_op, mo_size, mo_tag});
    for (int r = 0; r < NREQ; r++) begin
      chk("rsp_irdy", rsp_irdy_o[r], mr_v[r]);
      if (mr_v[r]) begin
        chk("rsp_data", rsp_data_o[r*512 +: 512], mr_data[r]);
        chk("rsp_meta", {rsp_acc_fault_o[r], rsp_poison_o[r], rsp_tag_o[r*2 +: 2]},
            {mr_f[r], mr_p[r], mr_tag[r]});
      end
    end
    chk("err", err_o, m_err);

    @(posedge clk);
    if (rst) begin
      mb_busy = '{default: 1'b0};
      mr_v    = '{default: 1'b0};
      mo_v    = 1'b0;
      m_last  = NREQ - 1;
      m_err   = 1'b0;
    end else begin
      load_idx = -1;
      if (m_rsp_irdy_i && e_mrsp) begin
        if (e_tbusy) load_idx = mt;
        else m_err = 1'b1;
      end
      for (int r = 0; r < NREQ; r++) begin
        if (r == load_idx) begin
          mr_v[r] = 1'b1; mr_data[r] = m_rsp_data_i; mr_f[r] = m_rsp_acc_fault_i;
          mr_p[r] = m_rsp_poison_i; mr_tag[r] = m_saved[r];
        end else if (mr_v[r] && rsp_trdy_i[r]) begin
          mr_v[r] = 1'b0; mb_busy[r] = 1'b0;
        end
      end
      if (e_win >= 0) begin
        mo_v    = 1'b1;
        mo_addr = req_addr_i[e_win*46 +: 46];
        mo_op   = req_op_i[e_win*2 +: 2];
        mo_size = req_size_i[e_win*7 +: 7];
        mo_tag  = e_win[1:0];
        m_last  = e_win;
        if (mo_op == LD || mo_op == AMO) begin
          mb_busy[e_win] = 1'b1;
          m_saved[e_win] = req_tag_i[e_win*2 +: 2];
        end
      end else if (m_req_trdy_i) begin
        mo_v = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int              glog[$];
  bit              last_mrsp;
  logic [NREQ-1:0] oneshot;

  task automatic tick();
    logic [NREQ-1:0] g;
    @(negedge clk);
    g = req_trdy_o;
    last_mrsp = m_rsp_irdy_i && m_rsp_trdy_o;
    for (int r = 0; r < NREQ; r++) if (g[r]) glog.push_back(r);
    @(posedge clk);
    #1;
    for (int r = 0; r < NREQ; r++) if (g[r] && oneshot[r]) req_irdy_i[r] = 1'b0;
  endtask

  task automatic set_req(input int r, input logic [45:0] a, input logic [1:0] op,
                         input logic [1:0] tg, input logic [6:0] sz);
    req_addr_i[r*46 +: 46] = a;
    req_op_i[r*2 +: 2]     = op;
    req_tag_i[r*2 +: 2]    = tg;
    req_size_i[r*7 +: 7]   = sz;
    req_irdy_i[r]          = 1'b1;
  endtask

  task automatic send_rsp(input logic [1:0] tg, input logic [511:0] d, input logic f, input logic p);
    bit done;
    done = 1'b0;
    m_rsp_tag_i = tg; m_rsp_data_i = d; m_rsp_acc_fault_i = f; m_rsp_poison_i = p;
    m_rsp_irdy_i = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      tick();
      done = last_mrsp;
    end
    m_rsp_irdy_i = 1'b0;
    chk("rsp_accept", done, 1'b1);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && req_irdy_i != 3'b000; n++) tick();
    tick();
    chk("drain", req_irdy_i, 3'b000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   exp_order[6] = '{0, 1, 2, 0, 1, 2};
    logic [45:0] held_addr;
    rst = 1'b1;
    req_addr_i = '0; req_op_i = '0; req_tag_i = '0; req_size_i = '0; req_irdy_i = '0;
    rsp_trdy_i = '0; m_req_trdy_i = 1'b1; m_rsp_data_i = '0; m_rsp_acc_fault_i = 1'b0;
    m_rsp_poison_i = 1'b0; m_rsp_tag_i = 2'd0; m_rsp_irdy_i = 1'b0;
    oneshot = '1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_rsp_irdy", rsp_irdy_o, 3'b000);
    chk("rst_err", err_o, 1'b0);
    chk("rst_m_req_irdy", m_req_irdy_o, 1'b0);

    // Single LOAD from r1
    set_req(1, 46'h1000, LD, 2'd2, 7'd64);
    glog.delete();
    tick();
    chk("t1_ngrant", glog.size(), 1);
    if (glog.size() > 0) chk("t1_winner", glog[0], 1);
    chk("t1_m_tag", m_req_tag_o, 2'd1);
    chk("t1_m_addr", m_req_addr_o, 46'h1000);
    set_req(1, 46'h1040, LD, 2'd1, 7'd64);
    glog.delete();
    repeat (3) tick();
    chk("t1_blocked", glog.size(), 0);
    send_rsp(2'd1, 512'h2001, 1'b0, 1'b0);
    chk("t1_rsp_irdy", rsp_irdy_o[1], 1'b1);
    chk("t1_rsp_data", rsp_data_o[512 +: 512], 512'h2001);
    chk("t1_rsp_tag", rsp_tag_o[2 +: 2], 2'd2);
    repeat (2) tick();
    rsp_trdy_i[1] = 1'b1;
    tick();
    rsp_trdy_i[1] = 1'b0;
    chk("t1_rsp_taken", rsp_irdy_o[1], 1'b0);
    chk("t1_no_bypass", glog.size(), 0);
    tick();
    chk("t1_regrant", glog.size(), 1);
    send_rsp(2'd1, 512'h55, 1'b1, 1'b0);
    rsp_trdy_i[1] = 1'b1;
    tick();
    rsp_trdy_i[1] = 1'b0;

    // Fairness with continuous STOREs
    rst = 1'b1; tick(); rst = 1'b0;
    oneshot = '0;
    set_req(0, 46'h100, ST, 2'd0, 7'd8);
    set_req(1, 46'h101, ST, 2'd0, 7'd8);
    set_req(2, 46'h102, 2'd3, 2'd0, 7'd8);
    glog.delete();
    repeat (6) tick();
    chk("fair_count", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("fair_order", glog[i], exp_order[i]);
    oneshot = '1;
    drain();

    // Downstream backpressure
    set_req(0, 46'h300, ST, 2'd0, 7'd4);
    set_req(2, 46'h302, ST, 2'd0, 7'd4);
    tick();
    m_req_trdy_i = 1'b0;
    held_addr = m_req_addr_o;
    chk("bp_first", held_addr, 46'h300);
    glog.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stable", m_req_addr_o, held_addr);
    end
    chk("bp_nogrant", glog.size(), 0);
    m_req_trdy_i = 1'b1;
    tick();
    chk("bp_resume", glog.size(), 1);
    chk("bp_second", m_req_addr_o, 46'h302);
    drain();

    // Response stall on r0, r2 still served
    set_req(0, 46'h400, LD, 2'd1, 7'd8);
    set_req(2, 46'h402, AMO, 2'd3, 7'd8);
    drain();
    send_rsp(2'd0, 512'hA0, 1'b0, 1'b1);
    send_rsp(2'd2, 512'hB2, 1'b0, 1'b0);
    m_rsp_tag_i = 2'd0; m_rsp_data_i = 512'hC0; m_rsp_poison_i = 1'b0; m_rsp_irdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_held", m_rsp_trdy_o, 1'b0);
    end
    rsp_trdy_i[0] = 1'b1;
    tick();
    m_rsp_irdy_i = 1'b0;
    chk("stall_reload", rsp_irdy_o[0], 1'b1);
    chk("stall_data", rsp_data_o[0 +: 512], 512'hC0);
    chk("stall_tag", rsp_tag_o[0 +: 2], 2'd1);
    tick();
    rsp_trdy_i[0] = 1'b0;
    chk("r2_data", rsp_data_o[1024 +: 512], 512'hB2);
    chk("r2_tag", rsp_tag_o[4 +: 2], 2'd3);
    rsp_trdy_i[2] = 1'b1;
    tick();
    rsp_trdy_i[2] = 1'b0;

    // Bad responses
    send_rsp(2'd3, 512'hDEAD, 1'b0, 1'b0);
    chk("bad_tag_err", err_o, 1'b1);
    chk("bad_tag_noirdy", rsp_irdy_o, 3'b000);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("bad_err_clr", err_o, 1'b0);
    send_rsp(2'd0, 512'hBEEF, 1'b0, 1'b0);
    chk("idle_tag_err", err_o, 1'b1);
    chk("idle_tag_noirdy", rsp_irdy_o, 3'b000);

    // Reset mid-operation
    m_req_trdy_i = 1'b0;
    set_req(2, 46'h600, LD, 2'd0, 7'd8);
    tick();
    chk("mid_irdy", m_req_irdy_o, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_irdy", m_req_irdy_o, 1'b0);
    chk("mid_rst_err", err_o, 1'b0);
    chk("mid_rst_rsp", rsp_irdy_o, 3'b000);
    m_req_trdy_i = 1'b1;
    set_req(0, 46'h700, ST, 2'd0, 7'd8);
    set_req(1, 46'h701, ST, 2'd0, 7'd8);
    set_req(2, 46'h702, ST, 2'd0, 7'd8);
    glog.delete();
    drain();
    chk("mid_ngrant", glog.size(), 3);
    if (glog.size() > 0) chk("mid_first", glog[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_iommu_ls_arbiter.md
# rv_iommu_ls_arbiter

Shares the single IOMMU memory load/store port among `NREQ` internal requesters: DDT/PDT walker, command-queue fetch, fault/page-request queue writer. Round-robin arbitration registers one request per cycle into the downstream port. Returned load/AMO data is routed back to the issuing requester by downstream tag. Each requester may have at most one response-bearing request outstanding.

## Interface
- `NREQ`, 3: number of requesters, legal 1..4; requester index r is 0..NREQ-1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `req_addr_i`  in  NREQ*46  per-requester address; slice r = [r*46 +: 46].
- `req_op_i`  in  NREQ*2  op: LOAD, STORE, AMO (consts encodings); other codes are treated as STORE.
- `req_tag_i`  in  NREQ*2  requester-private tag.
- `req_size_i`  in  NREQ*7  access size.
- `req_irdy_i`  in  NREQ  request valid.
- `req_trdy_o`  out  NREQ  request accepted (grant).
- `rsp_data_o`  out  NREQ*512  returned data.
- `rsp_acc_fault_o`  out  NREQ  access fault.
- `rsp_poison_o`  out  NREQ  data poisoned.
- `rsp_tag_o`  out  NREQ*2  echo of the requester tag.
- `rsp_irdy_o`  out  NREQ  response valid.
- `rsp_trdy_i`  in  NREQ  requester takes response.
- `m_req_addr_o`  out  46  downstream request address.
- `m_req_op_o`  out  2  downstream request op.
- `m_req_size_o`  out  7  downstream request size.
- `m_req_tag_o`  out  2  downstream tag = granted requester index.
- `m_req_irdy_o`  out  1  downstream request valid.
- `m_req_trdy_i`  in  1  downstream request ready.
- `m_rsp_data_i`  in  512  response data.
- `m_rsp_acc_fault_i`  in  1  response access fault.
- `m_rsp_poison_i`  in  1  response poison.
- `m_rsp_tag_i`  in  2  response tag.
- `m_rsp_irdy_i`  in  1  response valid.
- `m_rsp_trdy_o`  out  1  response accepted.
- `err_o`  out  1  sticky protocol error.

## Operation
- Transfer on every channel = irdy & trdy in the same cycle; irdy may not drop and payload may not change until transfer.
- Eligible requester r: `req_irdy_i[r]` & !`busy[r]`.
- Output register free: !`m_req_irdy_o` | `m_req_trdy_i`.
- Grant when the output register is free and any requester is eligible. Winner = first eligible index scanning from `rr_ptr+1` modulo NREQ.
- `req_trdy_o` is combinational one-hot of the winner, zero when there is no grant.
- On grant:
  - Output register loads addr/op/size, and tag = winner index.
  - `rr_ptr` <= winner.
  - For LOAD/AMO: `busy[winner]` <= 1 and `saved_tag[winner]` <= `req_tag_i` slice.
  - For STORE/other: no busy, no response expected.
- Response path, idx = `m_rsp_tag_i`. Per-requester 1-entry response register `rsp_irdy_o[r]`.
- `m_rsp_trdy_o` = idx<NREQ & busy[idx] & (!rsp_irdy_o[idx] | rsp_trdy_i[idx]). If idx>=NREQ or !busy[idx], `m_rsp_trdy_o`=1: response dropped, `err_o` set.
- Valid response transfer: load data/fault/poison into the idx register, `rsp_tag_o` = saved_tag, `rsp_irdy_o[idx]` <= 1.
- Requester response transfer: `rsp_irdy_o[r]` <= 0 and `busy[r]` <= 0, unless a new response for r loads in the same cycle.
- A requester becomes eligible again the cycle after its response transfer. No bypass from busy clear to grant in the same cycle.
- `err_o` clears only on reset.

## Timing
- Reset values:
  - All `*_irdy_o`, `busy`, `err_o` = 0.
  - `rr_ptr` = NREQ-1, so requester 0 wins first.
  - Data/tag/addr registers = 0.
  - `req_trdy_o` = 0 during reset.
  - `m_rsp_trdy_o` = 0 during reset.
- Request latency: grant in cycle N; `m_req_irdy_o` high in N+1.
- Full throughput: one grant per cycle while `m_req_trdy_i` stays high.
- Downstream stall (`m_req_trdy_i`=0): `m_req_*` held stable, no grants.
- Response latency: `m_rsp` transfer in cycle N; `rsp_irdy_o[idx]` high in N+1. Back-to-back responses to different requesters accepted every cycle.
- Reset mid-operation clears all state. Responses in flight downstream at reset are the system's responsibility: the block drops them and flags `err_o`.

## Test plan
- Single LOAD: r1 issues addr 0x1000, tag 2; downstream returns tag 1 with data 0x2001 → `m_req_tag_o`=1 one cycle after grant; `rsp_irdy_o[1]`=1, data 0x2001, `rsp_tag_o`=2; r1 blocked until `rsp_trdy_i[1]`.
- Fairness: all three requesters issue STOREs continuously with `m_req_trdy_i`=1 → grant order 0,1,2,0,1,2; one per cycle.
- Backpressure: `m_req_trdy_i`=0 for 5 cycles with 2 pending → `m_req_*` stable, `req_trdy_o`=0 throughout; grants resume the cycle `m_req_trdy_i` rises.
- Response stall: r0 holds `rsp_trdy_i[0]`=0 while its response arrives, then a second tag-0 response → second held off (`m_rsp_trdy_o`=0); tag-2 response accepted meanwhile.
- Bad response: tag 3 with NREQ=3, or tag 0 while not busy → accepted, no `rsp_irdy_o`, `err_o`=1 until reset.
- Reset mid-operation: assert `rst` with r2 busy and `m_req_irdy_o`=1 → next cycle all valids, busy, and `err_o` are 0; requester 0 wins the first grant.
